// File: rtl/reservation_station.sv
// Reservation station for non-memory instructions: holds dispatched ops until both
// operands are ready, snoops ALU/LSU broadcasts for wakeup, issues one op per cycle.
module reservation_station #(
    parameter int RS_SIZE  = 16,
    parameter int RS_IDX_W = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        en_signal_from_dispatcher,
    input  logic [5:0]  inst_name_from_dispatcher,
    input  logic [4:0]  Q1_from_dispatcher,
    input  logic [4:0]  Q2_from_dispatcher,
    input  logic [31:0] V1_from_dispatcher,
    input  logic [31:0] V2_from_dispatcher,
    input  logic [31:0] imm_from_dispatcher,
    input  logic [31:0] pc_from_dispatcher,
    input  logic [4:0]  rob_id_from_dispatcher,
    input  logic        valid_from_alu,
    input  logic [31:0] result_from_alu,
    input  logic [4:0]  rob_id_from_alu,
    input  logic        valid_from_lsu,
    input  logic [31:0] result_from_lsu,
    input  logic [4:0]  rob_id_from_lsu,
    input  logic        rollback_flag_from_rob,
    output logic        full_to_fetcher,
    output logic        en_signal_to_alu,
    output logic [5:0]  inst_name_to_alu,
    output logic [31:0] V1_to_alu,
    output logic [31:0] V2_to_alu,
    output logic [31:0] imm_to_alu,
    output logic [31:0] pc_to_alu,
    output logic [4:0]  rob_id_to_alu
);
    localparam logic [RS_IDX_W:0] FULL_TH = (RS_IDX_W+1)'(RS_SIZE - 1);

    logic [RS_SIZE-1:0] busy_q;
    logic [5:0]         inst_q [RS_SIZE];
    logic [4:0]         q1_q   [RS_SIZE];
    logic [4:0]         q2_q   [RS_SIZE];
    logic [31:0]        v1_q   [RS_SIZE];
    logic [31:0]        v2_q   [RS_SIZE];
    logic [31:0]        imm_q  [RS_SIZE];
    logic [31:0]        pc_q   [RS_SIZE];
    logic [4:0]         rob_q  [RS_SIZE];
    logic [RS_IDX_W:0]  count_q, count_d;

    logic               full_q, en_q;
    logic [5:0]         out_inst_q;
    logic [31:0]        out_v1_q, out_v2_q, out_imm_q, out_pc_q;
    logic [4:0]         out_rob_q;

    logic                has_free, has_rdy, do_ins, do_iss;
    logic [RS_IDX_W-1:0] free_idx, rdy_idx;
    logic [4:0]          ins_q1_d, ins_q2_d;
    logic [31:0]         ins_v1_d, ins_v2_d;

    // Downward scans so the lowest index wins.
    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        has_rdy  = 1'b0;
        rdy_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                has_free = 1'b1;
                free_idx = RS_IDX_W'(i);
            end
            if (busy_q[i] && q1_q[i] == 5'd0 && q2_q[i] == 5'd0) begin
                has_rdy = 1'b1;
                rdy_idx = RS_IDX_W'(i);
            end
        end
    end

    // Operands resolved by a broadcast in the insert cycle are stored ready.
    always_comb begin
        ins_q1_d = Q1_from_dispatcher;
        ins_v1_d = V1_from_dispatcher;
        ins_q2_d = Q2_from_dispatcher;
        ins_v2_d = V2_from_dispatcher;
        if (Q1_from_dispatcher != 5'd0) begin
            if (valid_from_alu && rob_id_from_alu == Q1_from_dispatcher) begin
                ins_q1_d = 5'd0;
                ins_v1_d = result_from_alu;
            end else if (valid_from_lsu && rob_id_from_lsu == Q1_from_dispatcher) begin
                ins_q1_d = 5'd0;
                ins_v1_d = result_from_lsu;
            end
        end
        if (Q2_from_dispatcher != 5'd0) begin
            if (valid_from_alu && rob_id_from_alu == Q2_from_dispatcher) begin
                ins_q2_d = 5'd0;
                ins_v2_d = result_from_alu;
            end else if (valid_from_lsu && rob_id_from_lsu == Q2_from_dispatcher) begin
                ins_q2_d = 5'd0;
                ins_v2_d = result_from_lsu;
            end
        end
    end

    assign do_ins  = en_signal_from_dispatcher && has_free;
    assign do_iss  = has_rdy;
    assign count_d = count_q + (RS_IDX_W+1)'(do_ins) - (RS_IDX_W+1)'(do_iss);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            en_q       <= 1'b0;
            out_inst_q <= '0;
            out_v1_q   <= '0;
            out_v2_q   <= '0;
            out_imm_q  <= '0;
            out_pc_q   <= '0;
            out_rob_q  <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                inst_q[i] <= '0;
                q1_q[i]   <= '0;
                q2_q[i]   <= '0;
                v1_q[i]   <= '0;
                v2_q[i]   <= '0;
                imm_q[i]  <= '0;
                pc_q[i]   <= '0;
                rob_q[i]  <= '0;
            end
        end else if (!rdy_in) begin
            en_q <= 1'b0;
        end else if (rollback_flag_from_rob) begin
            busy_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i]) begin
                    if (q1_q[i] != 5'd0) begin
                        if (valid_from_alu && rob_id_from_alu == q1_q[i]) begin
                            q1_q[i] <= 5'd0;
                            v1_q[i] <= result_from_alu;
                        end else if (valid_from_lsu && rob_id_from_lsu == q1_q[i]) begin
                            q1_q[i] <= 5'd0;
                            v1_q[i] <= result_from_lsu;
                        end
                    end
                    if (q2_q[i] != 5'd0) begin
                        if (valid_from_alu && rob_id_from_alu == q2_q[i]) begin
                            q2_q[i] <= 5'd0;
                            v2_q[i] <= result_from_alu;
                        end else if (valid_from_lsu && rob_id_from_lsu == q2_q[i]) begin
                            q2_q[i] <= 5'd0;
                            v2_q[i] <= result_from_lsu;
                        end
                    end
                end
            end
            en_q <= do_iss;
            if (do_iss) begin
                busy_q[rdy_idx] <= 1'b0;
                out_inst_q      <= inst_q[rdy_idx];
                out_v1_q        <= v1_q[rdy_idx];
                out_v2_q        <= v2_q[rdy_idx];
                out_imm_q       <= imm_q[rdy_idx];
                out_pc_q        <= pc_q[rdy_idx];
                out_rob_q       <= rob_q[rdy_idx];
            end
            // Free slot comes from the registered busy vector, so it never collides with the issuing slot.
            if (do_ins) begin
                busy_q[free_idx] <= 1'b1;
                inst_q[free_idx] <= inst_name_from_dispatcher;
                q1_q[free_idx]   <= ins_q1_d;
                q2_q[free_idx]   <= ins_q2_d;
                v1_q[free_idx]   <= ins_v1_d;
                v2_q[free_idx]   <= ins_v2_d;
                imm_q[free_idx]  <= imm_from_dispatcher;
                pc_q[free_idx]   <= pc_from_dispatcher;
                rob_q[free_idx]  <= rob_id_from_dispatcher;
            end
            count_q <= count_d;
            full_q  <= (count_d >= FULL_TH);
        end
    end

    assign full_to_fetcher  = full_q;
    assign en_signal_to_alu = en_q;
    assign inst_name_to_alu = out_inst_q;
    assign V1_to_alu        = out_v1_q;
    assign V2_to_alu        = out_v2_q;
    assign imm_to_alu       = out_imm_q;
    assign pc_to_alu        = out_pc_q;
    assign rob_id_to_alu    = out_rob_q;
endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station: insert/issue latency, wakeup,
// insert-time forwarding, full threshold, issue ordering, rollback and rdy_in freeze.
module tb_reservation_station;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, en_in, rollback;
    logic [5:0]  inst_in;
    logic [4:0]  q1_in, q2_in, rob_in, alu_tag, lsu_tag;
    logic [31:0] v1_in, v2_in, imm_in, pc_in, alu_val, lsu_val;
    logic        alu_vld, lsu_vld;
    logic        full_o, en_o;
    logic [5:0]  inst_o;
    logic [31:0] v1_o, v2_o, imm_o, pc_o;
    logic [4:0]  rob_o;

    int n_chk = 0;
    int n_fail = 0;

    reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .en_signal_from_dispatcher(en_in), .inst_name_from_dispatcher(inst_in),
        .Q1_from_dispatcher(q1_in), .Q2_from_dispatcher(q2_in),
        .V1_from_dispatcher(v1_in), .V2_from_dispatcher(v2_in),
        .imm_from_dispatcher(imm_in), .pc_from_dispatcher(pc_in),
        .rob_id_from_dispatcher(rob_in),
        .valid_from_alu(alu_vld), .result_from_alu(alu_val), .rob_id_from_alu(alu_tag),
        .valid_from_lsu(lsu_vld), .result_from_lsu(lsu_val), .rob_id_from_lsu(lsu_tag),
        .rollback_flag_from_rob(rollback),
        .full_to_fetcher(full_o), .en_signal_to_alu(en_o), .inst_name_to_alu(inst_o),
        .V1_to_alu(v1_o), .V2_to_alu(v2_o), .imm_to_alu(imm_o), .pc_to_alu(pc_o),
        .rob_id_to_alu(rob_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        en_in = 0; inst_in = 0; q1_in = 0; q2_in = 0; v1_in = 0; v2_in = 0;
        imm_in = 0; pc_in = 0; rob_in = 0;
        alu_vld = 0; alu_tag = 0; alu_val = 0;
        lsu_vld = 0; lsu_tag = 0; lsu_val = 0;
        rollback = 0;
    endtask

    task automatic ins(input logic [5:0] inst, input logic [4:0] q1, input logic [31:0] v1,
                       input logic [4:0] q2, input logic [31:0] v2, input logic [4:0] rob);
        en_in = 1; inst_in = inst; q1_in = q1; v1_in = v1; q2_in = q2; v2_in = v2;
        rob_in = rob; imm_in = 32'h100 + 32'(rob); pc_in = 32'h1000 + 32'(rob) * 4;
    endtask

    task automatic do_rollback();
        idle(); rollback = 1; tick(); rollback = 0;
    endtask

    task automatic test_reset();
        idle(); rdy_in = 1; rst_in = 1;
        tick(); tick();
        rst_in = 0;
        n_chk++; if (en_o !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", en_o); end
        n_chk++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full_o); end
        n_chk++; if (v1_o !== 32'd0 || rob_o !== 5'd0 || inst_o !== 6'd0 || pc_o !== 32'd0)
            begin n_fail++; $display("FAIL reset_data: v1=%h rob=%h inst=%h pc=%h want 0", v1_o, rob_o, inst_o, pc_o); end
    endtask

    task automatic test_ready_issue();
        ins(6'd1, 5'd0, 32'd5, 5'd0, 32'd7, 5'd3);
        tick(); idle();
        n_chk++; if (en_o !== 1'b0) begin n_fail++; $display("FAIL ready_early: got %b want 0", en_o); end
        tick();
        n_chk++; if (en_o !== 1'b1) begin n_fail++; $display("FAIL ready_en: got %b want 1", en_o); end
        n_chk++; if (v1_o !== 32'd5 || v2_o !== 32'd7 || rob_o !== 5'd3 || inst_o !== 6'd1)
            begin n_fail++; $display("FAIL ready_data: v1=%h v2=%h rob=%h inst=%h want 5 7 3 1", v1_o, v2_o, rob_o, inst_o); end
        n_chk++; if (imm_o !== 32'h103 || pc_o !== 32'h100c)
            begin n_fail++; $display("FAIL ready_imm_pc: imm=%h pc=%h want 103 100c", imm_o, pc_o); end
        tick();
        n_chk++; if (en_o !== 1'b0) begin n_fail++; $display("FAIL ready_pulse: got %b want 0", en_o); end
        n_chk++; if (v1_o !== 32'd5 || rob_o !== 5'd3)
            begin n_fail++; $display("FAIL ready_hold: v1=%h rob=%h want 5 3", v1_o, rob_o); end
    endtask

    task automatic test_wakeup();
        ins(6'd2, 5'd4, 32'd0, 5'd0, 32'd1, 5'd5);
        tick(); idle(); tick();
        n_chk++; if (en_o !== 1'b0) begin n_fail++; $display("FAIL wake_blocked: got %b want 0", en_o); end
        alu_vld = 1; alu_tag = 5'd4; alu_val = 32'h10;
        tick(); idle();
        n_chk++; if (en_o !== 1'b0) begin n_fail++; $display("FAIL wake_same_edge: got %b want 0", en_o); end
        tick();
        n_chk++; if (en_o !== 1'b1 || v1_o !== 32'h10 || v2_o !== 32'd1 || rob_o !== 5'd5)
            begin n_fail++; $display("FAIL wake_issue: en=%b v1=%h v2=%h rob=%h want 1 10 1 5", en_o, v1_o, v2_o, rob_o); end
        tick();
    endtask

    task automatic test_insert_forward();
        ins(6'd3, 5'd6, 32'd0, 5'd0, 32'd2, 5'd7);
        lsu_vld = 1; lsu_tag = 5'd6; lsu_val = 32'hAB;
        tick(); idle(); tick();
        n_chk++; if (en_o !== 1'b1 || v1_o !== 32'hAB || rob_o !== 5'd7)
            begin n_fail++; $display("FAIL fwd_lsu: en=%b v1=%h rob=%h want 1 ab 7", en_o, v1_o, rob_o); end
        tick();
    endtask

    task automatic test_dual_wakeup();
        ins(6'd4, 5'd14, 32'd0, 5'd15, 32'd0, 5'd8);
        tick(); idle();
        alu_vld = 1; alu_tag = 5'd14; alu_val = 32'hAAAA;
        lsu_vld = 1; lsu_tag = 5'd15; lsu_val = 32'hBBBB;
        tick(); idle(); tick();
        n_chk++; if (en_o !== 1'b1 || v1_o !== 32'hAAAA || v2_o !== 32'hBBBB || rob_o !== 5'd8)
            begin n_fail++; $display("FAIL dual_wake: en=%b v1=%h v2=%h rob=%h want 1 aaaa bbbb 8", en_o, v1_o, v2_o, rob_o); end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 15; i++) begin
            ins(6'd5, (i == 0) ? 5'd20 : 5'd9, 32'd0, 5'd0, 32'd0, 5'(i + 1));
            tick();
            if (i == 13) begin
                n_chk++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL full_at14: got %b want 0", full_o); end
            end
        end
        idle();
        n_chk++; if (full_o !== 1'b1) begin n_fail++; $display("FAIL full_at15: got %b want 1", full_o); end
        alu_vld = 1; alu_tag = 5'd20; alu_val = 32'h77;
        tick(); idle();
        n_chk++; if (full_o !== 1'b1 || en_o !== 1'b0)
            begin n_fail++; $display("FAIL full_wake: full=%b en=%b want 1 0", full_o, en_o); end
        tick();
        n_chk++; if (full_o !== 1'b0 || en_o !== 1'b1 || rob_o !== 5'd1 || v1_o !== 32'h77)
            begin n_fail++; $display("FAIL full_drain: full=%b en=%b rob=%h v1=%h want 0 1 1 77", full_o, en_o, rob_o, v1_o); end
        do_rollback();
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_rob [3];
        exp_rob[0] = 5'd20; exp_rob[1] = 5'd22; exp_rob[2] = 5'd25;
        for (int i = 0; i < 6; i++) begin
            ins(6'd6, (i == 0 || i == 2 || i == 5) ? 5'd11 : 5'd12, 32'd0, 5'd0, 32'd0, 5'(20 + i));
            tick();
        end
        idle();
        alu_vld = 1; alu_tag = 5'd11; alu_val = 32'h55;
        tick(); idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++; if (en_o !== 1'b1 || rob_o !== exp_rob[k] || v1_o !== 32'h55)
                begin n_fail++; $display("FAIL order_%0d: en=%b rob=%0d v1=%h want 1 %0d 55", k, en_o, rob_o, v1_o, exp_rob[k]); end
        end
        tick();
        n_chk++; if (en_o !== 1'b0) begin n_fail++; $display("FAIL order_end: got %b want 0", en_o); end
        do_rollback();
    endtask

    task automatic test_rollback();
        for (int i = 0; i < 8; i++) begin
            ins(6'd7, 5'd13, 32'd0, 5'd0, 32'd0, 5'(i + 1));
            tick();
        end
        ins(6'd8, 5'd0, 32'd1, 5'd0, 32'd2, 5'd30);
        rollback = 1;
        alu_vld = 1; alu_tag = 5'd13; alu_val = 32'h99;
        tick(); idle();
        n_chk++; if (en_o !== 1'b0 || full_o !== 1'b0)
            begin n_fail++; $display("FAIL rb_edge: en=%b full=%b want 0 0", en_o, full_o); end
        tick(); tick();
        n_chk++; if (en_o !== 1'b0) begin n_fail++; $display("FAIL rb_flushed: got %b want 0", en_o); end
        // count must restart at zero: full reappears only after 15 fresh inserts
        for (int i = 0; i < 15; i++) begin
            ins(6'd7, 5'd13, 32'd0, 5'd0, 32'd0, 5'(i + 1));
            tick();
            if (i == 13) begin
                n_chk++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL rb_count14: got %b want 0", full_o); end
            end
        end
        idle();
        n_chk++; if (full_o !== 1'b1) begin n_fail++; $display("FAIL rb_count15: got %b want 1", full_o); end
        do_rollback();
    endtask

    task automatic test_freeze();
        rdy_in = 0;
        ins(6'd9, 5'd0, 32'd3, 5'd0, 32'd4, 5'd11);
        tick(); idle(); tick();
        rdy_in = 1;
        tick();
        n_chk++; if (en_o !== 1'b0) begin n_fail++; $display("FAIL frz_no_insert: got %b want 0", en_o); end
        ins(6'd9, 5'd0, 32'd3, 5'd0, 32'd4, 5'd12);
        tick(); idle();
        rdy_in = 0;
        tick();
        n_chk++; if (en_o !== 1'b0) begin n_fail++; $display("FAIL frz_no_issue: got %b want 0", en_o); end
        tick();
        rdy_in = 1;
        tick();
        n_chk++; if (en_o !== 1'b1 || rob_o !== 5'd12 || v2_o !== 32'd4)
            begin n_fail++; $display("FAIL frz_resume: en=%b rob=%0d v2=%h want 1 12 4", en_o, rob_o, v2_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_ready_issue();
        test_wakeup();
        test_insert_forward();
        test_dual_wakeup();
        test_full();
        test_back_to_back();
        test_rollback();
        test_freeze();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
